// File: rtl/axi_pix_burst_reader.sv
// axi_pix_burst_reader: AXI4 read master that fetches a linear block of 32-bit pixel words
// and streams them out through a first-word-fall-through FIFO.
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | burst sized; waiting for FIFO room, then for arready
// DATA  | accepting beats of the single outstanding burst
// DRAIN | all bursts received; waiting for the FIFO to empty
module axi_pix_burst_reader #(
   parameter int ADDR_W     = 32,
   parameter int BURST_MAX  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [23:0]       word_count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic [31:0]       pix_data,
   output logic              pix_valid,
   input  logic              pix_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [23:0]       remaining, rem_after;
   logic [8:0]        len_q, beat_cnt, beat_n, len_now, len_next, len_start;
   logic [CW-1:0]     wr_ptr, rd_ptr, fifo_cnt, free_cnt;
   logic [31:0]       mem [FIFO_DEPTH];
   logic              push, pop, beat_last, space_now, space_next;

   // Beats for the next burst: capped by BURST_MAX, the words left, and the 4 KB page end.
   function automatic logic [8:0] calc_len(input logic [9:0] word_idx, input logic [23:0] rem);
      logic [23:0] l;
      logic [23:0] to_4k;
      to_4k = 24'd1024 - {14'd0, word_idx};
      l = 24'(BURST_MAX);
      if (to_4k < l) l = to_4k;
      if (rem < l) l = rem;
      return 9'(l);
   endfunction

   assign arsize    = 3'b010;
   assign arburst   = 2'b01;
   assign push      = rvalid && rready;
   assign pop       = pix_valid && pix_ready;
   assign fifo_cnt  = wr_ptr - rd_ptr;
   assign free_cnt  = CW'(FIFO_DEPTH) - fifo_cnt;
   assign pix_valid = (fifo_cnt != '0);
   assign pix_data  = mem[rd_ptr[CW-2:0]];

   assign beat_n     = beat_cnt + 9'd1;
   assign beat_last  = rlast || (beat_n == len_q);
   assign rem_after  = remaining - {15'd0, len_q};
   assign len_start  = calc_len(base_addr[11:2], word_count);
   assign len_now    = calc_len(addr_q[11:2], remaining);
   assign len_next   = calc_len(addr_q[11:2], rem_after);
   assign space_now  = (32'(free_cnt) >= 32'(len_now));
   // Room after the closing beat's push and any simultaneous pop.
   assign space_next = ((32'(free_cnt) + 32'(pop)) > 32'(len_next));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + CW'(1);
         if (pop)  rd_ptr <= rd_ptr + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[CW-2:0]] <= rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         remaining <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         araddr    <= '0;
         arlen     <= '0;
         arvalid   <= 1'b0;
         rready    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  err <= 1'b0;
                  if (word_count == 24'd0) begin
                     done <= 1'b1;
                  end else begin
                     // FIFO is always empty here, so the first burst can go out at once.
                     busy      <= 1'b1;
                     addr_q    <= base_addr;
                     remaining <= word_count;
                     len_q     <= len_start;
                     araddr    <= base_addr;
                     arlen     <= 8'(len_start - 9'd1);
                     arvalid   <= 1'b1;
                     state     <= ADDR;
                  end
               end
            end
            ADDR: begin
               if (arvalid) begin
                  if (arready) begin
                     arvalid  <= 1'b0;
                     rready   <= 1'b1;
                     addr_q   <= addr_q + ADDR_W'({len_q, 2'b00});
                     beat_cnt <= '0;
                     state    <= DATA;
                  end
               end else if (space_now) begin
                  arvalid <= 1'b1;
                  araddr  <= addr_q;
                  arlen   <= 8'(len_now - 9'd1);
                  len_q   <= len_now;
               end
            end
            DATA: begin
               if (push) begin
                  beat_cnt <= beat_n;
                  if (rresp != 2'b00) err <= 1'b1;
                  if (rlast != (beat_n == len_q)) err <= 1'b1;
                  if (beat_last) begin
                     rready    <= 1'b0;
                     remaining <= rem_after;
                     if (rem_after != 24'd0) begin
                        state <= ADDR;
                        if (space_next) begin
                           arvalid <= 1'b1;
                           araddr  <= addr_q;
                           arlen   <= 8'(len_next - 9'd1);
                           len_q   <= len_next;
                        end
                     end else begin
                        state <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               if ((fifo_cnt - CW'(pop)) == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/axi_pix_burst_reader.md
# axi_pix_burst_reader

AXI4 read master that fetches a linear block of 32-bit pixel words from DDR and presents them as a valid/ready stream to the DSI packet assembler. It sits between the pixel read-only AXI slave port of the memory fabric and the DSI pixel FIFO, and is the initiating end of that read interface. Bursts are issued only when the internal FIFO has room for the whole burst, so `rready` is never deasserted.

## Interface
- `ADDR_W`, 32: AXI address width.
- `BURST_MAX`, 16: maximum beats per burst, 1..256.
- `FIFO_DEPTH`, 64: output FIFO entries, power of two, at least `BURST_MAX`.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a transfer; ignored unless idle.
- `base_addr`  in  ADDR_W  byte address of the first word; must be 4-byte aligned; latched on `start`.
- `word_count`  in  24  number of 32-bit words to read; latched on `start`; 0 means no transfer.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the last word leaves the stream output.
- `err`  out  1  sticky error flag; cleared on an accepted `start`.
- `araddr`  out  ADDR_W  read address.
- `arlen`  out  8  burst beats minus one.
- `arsize`  out  3  constant 3'b010.
- `arburst`  out  2  constant 2'b01 (INCR).
- `arvalid`  out  1  read address valid.
- `arready`  in  1  read address accepted.
- `rdata`  in  32  read data.
- `rresp`  in  2  read response.
- `rlast`  in  1  last beat of the burst.
- `rvalid`  in  1  read data valid.
- `rready`  out  1  read data ready.
- `pix_data`  out  32  output word.
- `pix_valid`  out  1  output valid.
- `pix_ready`  in  1  downstream ready.

## Operation
- States: IDLE, ADDR, DATA, DRAIN.
- IDLE: on `start` with `word_count` = 0, pulse `done` on the next cycle and stay in IDLE. On `start` with `word_count` > 0, latch the address and count, clear `err`, set `busy`, then go to ADDR.
- Burst length: `len = min(BURST_MAX, remaining, words_to_4KB)`, where `words_to_4KB = (4096 - addr[11:0]) / 4`. A burst never crosses a 4 KB boundary.
- ADDR: wait until FIFO free entries ≥ `len`. Then drive `arvalid` = 1 with `araddr` = current address and `arlen` = `len` - 1. Hold all three stable until `arready`. On the handshake, advance the address by 4·`len` and go to DATA.
- DATA: `rready` = 1. Every `rvalid` beat is pushed into the FIFO. When `rresp` ≠ 0, set `err`; the data is still pushed.
- Beat counting:
  - If `rlast` arrives before `len` beats, set `err` and treat the burst as complete.
  - If `rlast` is missing on beat `len`, set `err` and also treat the burst as complete.
- Burst end: after the last beat, decrement `remaining` by `len`. If `remaining` > 0, go to ADDR; otherwise go to DRAIN.
- Outstanding bursts: only one burst is outstanding at a time.
- DRAIN: when the FIFO is empty (the final word has been handshaken on `pix_*`), pulse `done` for one cycle, clear `busy`, and go to IDLE.
- FIFO: synchronous, first-word-fall-through. `pix_valid` = not empty. Pop on `pix_valid && pix_ready`. A push and a pop in the same cycle are both performed. Overflow is impossible by construction.
- `start` while `busy` is ignored.

## Timing
- Reset values: `arvalid`=0, `rready`=0, `pix_valid`=0, `busy`=0, `done`=0, `err`=0, `araddr`=0, `arlen`=0. The FIFO is emptied and the state is IDLE.
- Reset mid-transfer aborts immediately. Any beats in flight are the fabric's responsibility.
- `start` → `arvalid` high: 1 cycle later, provided FIFO space is available.
- `arready` handshake → `rready` high: next cycle.
- `rvalid` beat → `pix_valid` high: 1 cycle (registered push, FWFT read).
- ADDR re-entry after the last beat of a burst: next cycle. The next `arvalid` can assert in that same cycle if space allows.
- `done` asserts in the cycle after the final pop handshake. `busy` falls in that same cycle.
- Throughput: 1 word/cycle sustained while `pix_ready` = 1, apart from the AR round-trip between bursts.

## Test plan
- **Basic:** `base_addr`=0x0000_1000, `word_count`=40, slave returns beat value = address, `pix_ready`=1.
  - Expect ARs of (0x1000, arlen 15), (0x1040, 15), (0x1080, 7).
  - Expect 40 output words 0x1000..0x109C in order.
  - Expect `done` once and `err`=0.
- **4 KB split:** `base_addr`=0x0000_0FF0, `word_count`=16.
  - Expect ARs (0x0FF0, arlen 3) then (0x1000, arlen 11).
  - Expect 16 words output.
- **Backpressure:** `word_count`=200, `FIFO_DEPTH`=64, `pix_ready` low for the first 500 cycles.
  - No AR is issued once fewer than 16 entries are free.
  - `rready` is never low while in DATA.
  - All 200 words are delivered once `pix_ready` rises.
- **Error response:** beat 5 of the first burst returns `rresp`=2'b10.
  - Expect `err`=1 from the next cycle and all words still delivered.
  - The next `start` clears `err`.
- **Early `rlast`:** `rlast` on beat 3 of a 16-beat burst.
  - Expect `err`=1 and a new AR for the remaining words.
  - Expect `done` when the FIFO is empty.
- **Reset and zero count:**
  - `rst` pulse during DATA → all outputs return to reset values; a subsequent `start` with `word_count`=4 completes normally.
  - `start` with `word_count`=0 → `done` one cycle later, no AR issued.
